// File: rtl/pulpemu_rst_seq.sv
// Reset/boot sequencer for the PULP emulation platform: waits for clock lock,
// holds reset for a fixed time, latches the boot strap and releases pad_reset_n.
module pulpemu_rst_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pll_locked_i,
    input  logic             ext_rst_req_i,
    input  logic             bootmode_i,
    output logic             pulp_rst_no,
    output logic             bootmode_o,
    output logic             rst_done_o,
    output logic [CNT_W-1:0] rst_count_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        HOLD       = 2'd1,
        BOOT_LATCH = 2'd2,
        RUN        = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_lockSync;
    logic [SYNC_STAGES-1:0] r_reqSync;
    logic [SYNC_STAGES-1:0] r_bootSync;
    logic                   w_lockS;
    logic                   w_reqS;
    logic                   w_bootS;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [HOLD_W-1:0]      r_holdCnt;
    logic [HOLD_W-1:0]      w_holdNext;
    logic [DB_W-1:0]        r_dbCnt;
    logic                   r_armed;
    logic                   w_fire;
    logic                   w_runExit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lockSync <= '0;
            r_reqSync  <= '0;
            r_bootSync <= '0;
        end else begin
            r_lockSync[0] <= pll_locked_i;
            r_reqSync[0]  <= ext_rst_req_i;
            r_bootSync[0] <= bootmode_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_lockSync[i] <= r_lockSync[i-1];
                r_reqSync[i]  <= r_reqSync[i-1];
                r_bootSync[i] <= r_bootSync[i-1];
            end
        end
    end

    assign w_lockS = r_lockSync[SYNC_STAGES-1];
    assign w_reqS  = r_reqSync[SYNC_STAGES-1];
    assign w_bootS = r_bootSync[SYNC_STAGES-1];

    // A held request fires only once; re-arming needs the request to drop first.
    assign w_fire = r_armed && (r_dbCnt == DB_W'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dbCnt <= '0;
            r_armed <= 1'b0;
        end else if (!w_reqS) begin
            r_dbCnt <= '0;
            r_armed <= 1'b1;
        end else begin
            if (r_dbCnt != DB_W'(DEBOUNCE_CYCLES)) begin
                r_dbCnt <= r_dbCnt + DB_W'(1);
            end
            if (w_fire) begin
                r_armed <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_holdNext  = '0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lockS) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (!w_lockS) begin
                    w_nextState = WAIT_LOCK;
                end else if (r_holdCnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_nextState = BOOT_LATCH;
                end else begin
                    w_holdNext = r_holdCnt + HOLD_W'(1);
                end
            end
            BOOT_LATCH: begin
                w_nextState = w_lockS ? RUN : WAIT_LOCK;
            end
            RUN: begin
                if (!w_lockS || w_fire) begin
                    w_nextState = WAIT_LOCK;
                end
            end
            default: begin
                w_nextState = WAIT_LOCK;
            end
        endcase
    end

    assign w_runExit = (r_state == RUN) && (w_nextState == WAIT_LOCK);

    // Outputs are registered from the next state so they change together with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= WAIT_LOCK;
            r_holdCnt   <= '0;
            pulp_rst_no <= 1'b0;
            rst_done_o  <= 1'b0;
            bootmode_o  <= 1'b0;
            rst_count_o <= '0;
        end else begin
            r_state     <= w_nextState;
            r_holdCnt   <= w_holdNext;
            pulp_rst_no <= (w_nextState == RUN);
            rst_done_o  <= (w_nextState == RUN);
            if (r_state == BOOT_LATCH) begin
                bootmode_o <= w_bootS;
            end
            if (w_runExit && (rst_count_o != {CNT_W{1'b1}})) begin
                rst_count_o <= rst_count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulpemu_rst_seq.sv
// Directed scoreboard bench for pulpemu_rst_seq: lock/hold latency, strap latch,
// debounce, lock loss, async reset and counter saturation on a 2-bit instance.
module tb_pulpemu_rst_seq;

    logic       clk;
    logic       rst;
    logic       pllLocked;
    logic       extRstReq;
    logic       bootmodeIn;

    logic       pulpRstN;
    logic       bootmodeOut;
    logic       rstDone;
    logic [7:0] rstCount;

    logic       pulpRstN2;
    logic       bootmodeOut2;
    logic       rstDone2;
    logic [1:0] rstCount2;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    pulpemu_rst_seq dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pll_locked_i (pllLocked),
        .ext_rst_req_i(extRstReq),
        .bootmode_i   (bootmodeIn),
        .pulp_rst_no  (pulpRstN),
        .bootmode_o   (bootmodeOut),
        .rst_done_o   (rstDone),
        .rst_count_o  (rstCount)
    );

    pulpemu_rst_seq #(.CNT_W(2)) dutSat (
        .clk_i        (clk),
        .rst_i        (rst),
        .pll_locked_i (pllLocked),
        .ext_rst_req_i(extRstReq),
        .bootmode_i   (bootmodeIn),
        .pulp_rst_no  (pulpRstN2),
        .bootmode_o   (bootmodeOut2),
        .rst_done_o   (rstDone2),
        .rst_count_o  (rstCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pll, input logic req, input logic boot);
        pllLocked  = pll;
        extRstReq  = req;
        bootmodeIn = boot;
    endtask

    // sel: 0 pulp_rst_no, 1 bootmode_o, 2 rst_done_o, 3 rst_count_o, 4 saturating-instance count
    task automatic expectOut(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] obs;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            case (e.sel)
                0:       obs = {7'd0, pulpRstN};
                1:       obs = {7'd0, bootmodeOut};
                2:       obs = {7'd0, rstDone};
                3:       obs = rstCount;
                default: obs = {6'd0, rstCount2};
            endcase
            assertCount++;
            assert (obs === e.val) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        step(3);
        expectOut("reset_pulp", 0, 8'd0);
        expectOut("reset_boot", 1, 8'd0);
        expectOut("reset_done", 2, 8'd0);
        expectOut("reset_cnt",  3, 8'd0);
        checkOutput();

        // Lock already present at release: RUN exactly 68 cycles later.
        rst = 1'b0;
        step(67);
        expectOut("lat_pulp_c67", 0, 8'd0);
        expectOut("lat_done_c67", 2, 8'd0);
        checkOutput();
        step(1);
        expectOut("lat_pulp_c68", 0, 8'd1);
        expectOut("lat_done_c68", 2, 8'd1);
        expectOut("lat_boot",     1, 8'd1);
        expectOut("lat_cnt",      3, 8'd0);
        checkOutput();

        // Async reset in RUN must drop outputs without any clock edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        expectOut("async_pulp", 0, 8'd0);
        expectOut("async_done", 2, 8'd0);
        expectOut("async_boot", 1, 8'd0);
        expectOut("async_cnt",  3, 8'd0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(3);
        rst = 1'b0;
        step(5);
        expectOut("nolock_pulp", 0, 8'd0);
        checkOutput();

        // Lock drops at hold count 30, then relock restarts the full hold.
        applyStimulus(1'b1, 1'b0, 1'b1);
        step(31);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(3);
        expectOut("holddrop_pulp", 0, 8'd0);
        expectOut("holddrop_cnt",  3, 8'd0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b1);
        step(67);
        expectOut("relock_pulp_c67", 0, 8'd0);
        checkOutput();
        step(1);
        expectOut("relock_pulp_c68", 0, 8'd1);
        expectOut("relock_cnt",      3, 8'd0);
        checkOutput();

        // Strap changes in RUN are ignored.
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(10);
        expectOut("boot_frozen", 1, 8'd1);
        expectOut("boot_run",    0, 8'd1);
        checkOutput();

        // 15-cycle request is too short to fire.
        applyStimulus(1'b1, 1'b1, 1'b0);
        step(15);
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(10);
        expectOut("req15_pulp", 0, 8'd1);
        expectOut("req15_cnt",  3, 8'd0);
        checkOutput();

        // Request held 500 cycles resets once, then PULP reboots under the held request.
        applyStimulus(1'b1, 1'b1, 1'b0);
        step(20);
        expectOut("req16_pulp", 0, 8'd0);
        expectOut("req16_cnt",  3, 8'd1);
        checkOutput();
        step(480);
        expectOut("held_pulp", 0, 8'd1);
        expectOut("held_cnt",  3, 8'd1);
        expectOut("held_boot", 1, 8'd0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(10);
        expectOut("released_pulp", 0, 8'd1);
        expectOut("released_cnt",  3, 8'd1);
        checkOutput();

        // After release the debouncer re-arms.
        applyStimulus(1'b1, 1'b1, 1'b0);
        step(20);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("rearm_pulp", 0, 8'd0);
        expectOut("rearm_cnt",  3, 8'd2);
        expectOut("rearm_cnt2", 4, 8'd2);
        checkOutput();
        step(70);
        expectOut("rearm_run", 0, 8'd1);
        checkOutput();

        // Five lock-loss exits: wide counter keeps counting, 2-bit one saturates.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            step(5);
            expectOut("loss_pulp", 0, 8'd0);
            checkOutput();
            applyStimulus(1'b1, 1'b0, 1'b0);
            step(68);
            expectOut("loss_run", 0, 8'd1);
            expectOut("loss_cnt", 3, 8'(k + 3));
            checkOutput();
        end
        expectOut("sat_cnt2", 4, 8'd3);
        expectOut("wide_cnt", 3, 8'd7);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
